// File: rtl/cv32e40s_lsu_write_buffer.sv
// rtl/cv32e40s_lsu_write_buffer.sv - write buffer for bufferable stores ahead of the OBI data request channel
//
// cv32e40s_pkg       : OBI data request payload type shared with the testbench.
// cv32e40s_lsu_write_buffer
//   clk, rst_n       : clock, synchronous active-low reset
//   valid_i, trans_i : upstream transfer (from the response filter)
//   ready_o          : upstream transfer accepted this cycle
//   valid_o, trans_o : OBI data request
//   ready_i          : OBI grant
//   empty_o          : no stores buffered

package cv32e40s_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [5:0]  atop;
        logic [1:0]  memtype;
        logic [2:0]  prot;
        logic        dbg;
    } obi_data_req_t;

endpackage

module cv32e40s_lsu_write_buffer
    import cv32e40s_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    input  obi_data_req_t trans_i,
    output logic          ready_o,
    output logic          valid_o,
    output obi_data_req_t trans_o,
    input  logic          ready_i,
    output logic          empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    obi_data_req_t fifo [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic bufferable;
    logic push;
    logic pop;
    logic empty;

    assign bufferable = trans_i.we && trans_i.memtype[0];
    assign empty      = (count == '0);
    assign empty_o    = empty;

    always_comb begin
        valid_o = valid_i;
        trans_o = trans_i;
        ready_o = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        if (empty) begin
            // Pass-through. A stalled bufferable store is still accepted and
            // captured; its buffered copy is what the bus sees next cycle, so
            // the OBI payload stays stable even if upstream moves on.
            ready_o = bufferable ? 1'b1 : ready_i;
            push    = valid_i && bufferable && !ready_i;
        end else begin
            // Drain. Non-bufferable transfers wait until the buffer is empty
            // so bus order always matches program order.
            valid_o = 1'b1;
            trans_o = fifo[rd_ptr];
            ready_o = bufferable && (count < CW'(DEPTH));
            push    = valid_i && ready_o;
            pop     = ready_i;
        end
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset; count/pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= trans_i;
        end
    end

endmodule

// File: tb/tb_cv32e40s_lsu_write_buffer.sv
// tb/tb_cv32e40s_lsu_write_buffer.sv - randomized and directed bench for cv32e40s_lsu_write_buffer

module tb_cv32e40s_lsu_write_buffer;
    import cv32e40s_pkg::*;

    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_i;
    obi_data_req_t trans_i;
    logic          ready_o;
    logic          valid_o;
    obi_data_req_t trans_o;
    logic          ready_i;
    logic          empty_o;

    always #5 clk = ~clk;

    cv32e40s_lsu_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .trans_i (trans_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .trans_o (trans_o),
        .ready_i (ready_i),
        .empty_o (empty_o)
    );

    int total = 0;
    int bad   = 0;

    obi_data_req_t held[$];
    obi_data_req_t prog[$];
    logic          prev_stall = 1'b0;
    obi_data_req_t prev_trans;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic obi_data_req_t mk(input logic [31:0] addr, input logic we, input logic [1:0] mt);
        obi_data_req_t t;
        t.addr    = addr;
        t.be      = 4'($urandom);
        t.we      = we;
        t.wdata   = $urandom;
        t.atop    = '0;
        t.memtype = mt;
        t.prot    = 3'($urandom);
        t.dbg     = 1'b0;
        return t;
    endfunction

    task automatic cycle(input logic v, input obi_data_req_t t, input logic r, input logic rn);
        logic          buff;
        logic          ev;
        logic          er;
        logic          was_held;
        obi_data_req_t et;
        obi_data_req_t first;
        valid_i = v;
        trans_i = t;
        ready_i = r;
        rst_n   = rn;
        #4;
        buff     = t.we && t.memtype[0];
        was_held = (held.size() != 0);
        if (!was_held) begin
            ev = v;
            et = t;
            er = buff ? 1'b1 : r;
        end else begin
            ev = 1'b1;
            et = held[0];
            er = buff && (held.size() < DEPTH);
        end
        check("valid_o", 128'(valid_o), 128'(ev));
        check("ready_o", 128'(ready_o), 128'(er));
        check("empty_o", 128'(empty_o), 128'(!was_held));
        if (ev) check("trans_o", 128'(trans_o), 128'(et));
        if (prev_stall) check("obi_stable", 128'(trans_o), 128'(prev_trans));
        if (rn) begin
            if (v && er) prog.push_back(t);
            if (ev && r) begin
                if (prog.size() == 0) begin
                    check("bus_unexpected", 128'(1), 128'(0));
                end else begin
                    first = prog.pop_front();
                    check("bus_order", 128'(trans_o), 128'(first));
                end
            end
        end
        if (!rn) begin
            held.delete();
            prog.delete();
        end else begin
            if (was_held && r) void'(held.pop_front());
            if (v && er && buff && (was_held || !r)) held.push_back(t);
        end
        prev_stall = rn && ev && !r && (held.size() != 0);
        prev_trans = et;
        @(posedge clk);
        #1;
    endtask

    obi_data_req_t idle;
    obi_data_req_t third;

    initial begin
        idle = '0;
        valid_i = 1'b0;
        trans_i = '0;
        ready_i = 1'b0;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        cycle(0, idle, 0, 0);
        cycle(1, mk(32'h200, 0, 2'b00), 0, 0);

        // pass-through load
        cycle(1, mk(32'h40, 0, 2'b00), 1, 1);
        cycle(0, idle, 1, 1);

        // stalled bufferable store held for 3 stall cycles
        cycle(1, mk(32'h100, 1, 2'b01), 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, idle, 0, 1);
        check("stall_addr", 128'(trans_o.addr), 128'(32'h100));
        cycle(0, idle, 1, 1);
        cycle(0, idle, 0, 1);

        // full at DEPTH=2
        third = mk(32'h18, 1, 2'b11);
        cycle(1, mk(32'h10, 1, 2'b01), 0, 1);
        cycle(1, mk(32'h14, 1, 2'b01), 0, 1);
        cycle(1, third, 0, 1);
        cycle(1, third, 1, 1);
        cycle(1, third, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, idle, 1, 1);

        // non-bufferable load waits behind a buffered store
        cycle(1, mk(32'h20, 1, 2'b01), 0, 1);
        cycle(1, mk(32'h80, 0, 2'b00), 0, 1);
        cycle(1, mk(32'h80, 0, 2'b00), 1, 1);
        cycle(1, mk(32'h80, 0, 2'b00), 1, 1);
        cycle(1, mk(32'h84, 1, 2'b00), 1, 1);

        // back-to-back stores with alternating grant
        for (int i = 0; i < 6; i++) cycle(1, mk(32'h300 + 32'(4 * i), 1, 2'b01), 1'(i % 2), 1);
        for (int i = 0; i < 3; i++) cycle(0, idle, 1, 1);

        // reset mid-drain
        cycle(1, mk(32'h400, 1, 2'b01), 0, 1);
        cycle(1, mk(32'h404, 1, 2'b01), 0, 1);
        cycle(1, mk(32'h408, 0, 2'b00), 0, 0);
        cycle(1, mk(32'h40c, 0, 2'b00), 1, 1);
        cycle(0, idle, 1, 1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  mk($urandom & 32'hfffc, 1'($urandom), 2'($urandom)),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 60) != 0));
        end
        for (int i = 0; i < 4; i++) cycle(0, idle, 1, 1);
        check("drained", 128'(prog.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cv32e40s_lsu_write_buffer.md
# cv32e40s_lsu_write_buffer

Write buffer between the LSU response filter and the OBI data bus request channel. Bufferable stores (trans_i.we=1, trans_i.memtype[0]=1) are accepted into a DEPTH-entry FIFO even when the bus stalls. They are then issued in order to the bus. Loads and non-bufferable stores pass straight through only when the buffer is empty, so bus order always equals program order.

## Interface
Parameters:
- DEPTH, default 2: number of buffered store entries; legal range DEPTH >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- valid_i  input  1  upstream transfer valid (from response filter valid_o).
- trans_i  input  obi_data_req_t  upstream transfer.
- ready_o  output  1  transfer accepted by this block when valid_i && ready_o.
- valid_o  output  1  OBI data request valid.
- trans_o  output  obi_data_req_t  OBI data request payload.
- ready_i  input  1  OBI grant; bus transfer occurs when valid_o && ready_i.
- empty_o  output  1  high when no entries are buffered.

## Operation
- State: FIFO array [DEPTH] of obi_data_req_t, rd_ptr and wr_ptr, and count.
  - rd_ptr and wr_ptr are $clog2(DEPTH) bits, minimum 1 bit.
  - count is $clog2(DEPTH+1) bits.
- bufferable = trans_i.we && trans_i.memtype[0].
- count == 0 (pass-through):
  - valid_o = valid_i and trans_o = trans_i.
  - Non-bufferable transfer: ready_o = ready_i; nothing is written.
  - Bufferable transfer with ready_i=1: ready_o=1 and it goes directly to the bus; nothing is written.
  - Bufferable transfer with ready_i=0: ready_o=1; the transfer is written at wr_ptr and count becomes 1.
- count > 0 (drain):
  - valid_o = 1 and trans_o = fifo[rd_ptr].
  - Pop on valid_o && ready_i.
  - Incoming bufferable: ready_o = (count < DEPTH); push on valid_i && ready_o.
  - Incoming non-bufferable: ready_o = 0 until count == 0.
- Simultaneous push and pop: both pointers advance and count is unchanged.
- A push is refused when count == DEPTH, even if a pop occurs in the same cycle.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0. This applies to non-power-of-two DEPTH as well.
- empty_o = (count == 0).
- Reset (rst_n low at a clock edge) sets count=0, rd_ptr=0 and wr_ptr=0.
  - FIFO contents are not reset.
  - Buffered stores are discarded; reset mid-drain drops them without issue.

## Timing
- Zero-latency combinational path valid_i/trans_i -> valid_o/trans_o when empty.
- Combinational path ready_i -> ready_o exists only when empty.
- A buffered store is issued no earlier than the cycle after it is written.
- OBI stability: once valid_o=1 with ready_i=0, trans_o stays unchanged until grant.
  - The empty-and-stalled bufferable case satisfies this because the buffered copy of trans_i is presented the next cycle.
- Reset values after a reset edge:
  - empty_o=1, and ready_o follows ready_i.
  - valid_o follows valid_i; trans_o follows trans_i.
- Throughput: one transfer per cycle in each direction when ready_i=1.

## Test plan
- Pass-through: empty, load with valid_i=1 and ready_i=1 -> same cycle valid_o=1, trans_o=trans_i, ready_o=1; empty_o stays 1.
- Stalled bufferable store: empty, store to 0x100 with memtype=2'b01 and ready_i=0 -> ready_o=1 and empty_o=0 next cycle. trans_o.addr stays 0x100 for 3 stall cycles; on ready_i=1, empty_o returns to 1.
- Full at DEPTH=2: two bufferable stores to 0x10 and 0x14 accepted with ready_i=0.
  - A third bufferable store sees ready_o=0.
  - After one grant, the third is accepted.
  - Bus order is 0x10, 0x14, third store.
- Ordering: buffer holds 1 store and a non-bufferable load is presented -> ready_o=0 until the store is granted. Then the load passes in the following cycle with valid_o=1 and trans_o = load.
- Simultaneous push/pop and wrap: 6 back-to-back bufferable stores with ready_i alternating 0/1.
  - count never exceeds 2.
  - Pointers wrap 1->0.
  - All 6 addresses appear in order exactly once.
- Reset mid-drain: 2 entries buffered, rst_n=0 for one edge -> empty_o=1 and valid_o=valid_i next cycle; no buffered store is issued.
